// File: rtl/alu_16_pkg.sv
// Shared types for the alu_16 command queue: widths, FSM states and the queued command format.
package alu_16_pkg;
  localparam int SEL_W = 2;
  localparam int ALU_W = 16;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  typedef struct packed {
    logic [ALU_W-1:0] in1;
    logic [ALU_W-1:0] in2;
    logic [SEL_W-1:0] sel;
  } cmd_t;
endpackage

// File: rtl/alu_16_cmd_fifo.sv
// Synchronous FIFO with synchronous active-high reset; DEPTH must be a power of two >= 2.
module alu_16_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/alu_16_cmd_queue.sv
// Back-pressured command stage for alu_16: FIFO -> registered operands -> registered result.
// Optional ALU_CMD_STATS_EN adds stat_done (wrapping) and stat_stall (saturating) counters.
module alu_16_cmd_queue
  import alu_16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [W-1:0]           cmd_in1,
  input  logic [W-1:0]           cmd_in2,
  input  logic [1:0]             cmd_sel,
  output logic [W-1:0]           alu_in1,
  output logic [W-1:0]           alu_in2,
  output logic [1:0]             alu_sel,
  input  logic [W-1:0]           alu_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_data,
  output logic [1:0]             res_sel,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef ALU_CMD_STATS_EN
  ,
  output logic [15:0]            stat_done,
  output logic [15:0]            stat_stall
`endif
);
  cmd_t   wcmd, head;
  logic   full, empty, pop, capture;
  state_t state, state_nxt;

  assign wcmd.in1  = cmd_in1;
  assign wcmd.in2  = cmd_in2;
  assign wcmd.sel  = cmd_sel;
  assign cmd_ready = !full;

  alu_16_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .wdata (wcmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (res_ready) begin
        // Chain straight into the next command to reach 1 result / 2 cycles.
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // HOLD is entered only by the EXEC capture edge, so the state bit is the result-valid flop.
  assign res_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_sel  <= '0;
      res_data <= '0;
      res_sel  <= '0;
    end else begin
      if (pop) begin
        alu_in1 <= head.in1;
        alu_in2 <= head.in2;
        alu_sel <= head.sel;
      end
      if (capture) begin
        res_data <= alu_out;
        res_sel  <= alu_sel;
      end
    end
  end

`ifdef ALU_CMD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done  <= '0;
      stat_stall <= '0;
    end else begin
      if (res_valid && res_ready) stat_done <= stat_done + 16'd1;
      if (cmd_valid && !cmd_ready && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_16_cmd_queue.sv
// Bench for alu_16_cmd_queue: transaction model + result scoreboard, directed vectors with literal pins.
module tb_alu_16_cmd_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, res_ready;
  logic [15:0] cmd_in1, cmd_in2, alu_in1, alu_in2, alu_out, res_data;
  logic [1:0]  cmd_sel, alu_sel, res_sel;
  logic        cmd_ready, res_valid;
  logic [2:0]  fifo_count;
`ifdef ALU_CMD_STATS_EN
  logic [15:0] stat_done, stat_stall;
`endif

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
    case (s)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_out = alu(alu_in1, alu_in2, alu_sel);

  alu_16_cmd_queue #(.DEPTH(DEPTH), .W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_sel(cmd_sel),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sel(res_sel),
    .fifo_count(fifo_count)
`ifdef ALU_CMD_STATS_EN
    , .stat_done(stat_done), .stat_stall(stat_stall)
`endif
  );

  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- transaction model ----------------
  typedef struct { logic [15:0] a, b; logic [1:0] s; } mcmd_t;
  mcmd_t       mq[$];
  logic [15:0] sb_d[$];
  logic [1:0]  sb_s[$];
  logic [15:0] got_d[$];
  logic [1:0]  got_s[$];
  int          got_c[$];
  logic [15:0] m_a, m_b, m_res, m_done, m_stall;
  logic [1:0]  m_s, m_rsel;
  bit          m_exec, m_hold, m_init = 0;
  bit          prev_valid = 0;
  logic [15:0] prev_d;
  logic [1:0]  prev_s;
  int          cyc = 0, mn;
  mcmd_t       mc;

  function automatic void m_issue();
    mcmd_t c;
    c = mq.pop_front();
    m_a = c.a; m_b = c.b; m_s = c.s;
    m_exec = 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete(); sb_d.delete(); sb_s.delete();
      m_a = 0; m_b = 0; m_s = 0; m_res = 0; m_rsel = 0;
      m_exec = 0; m_hold = 0; m_done = 0; m_stall = 0;
      m_init = 1;
    end else if (m_init) begin
      mn = mq.size();
      if (cmd_valid && mn >= DEPTH && m_stall != 16'hFFFF) m_stall++;
      // result actually handed over by the DUT at this edge
      if (prev_valid && res_ready) begin
        chk("sb_expected_result", sb_d.size() > 0, 1);
        if (sb_d.size() > 0) begin
          chk("sb_data", prev_d, sb_d.pop_front());
          chk("sb_sel", prev_s, sb_s.pop_front());
        end
        got_d.push_back(prev_d); got_s.push_back(prev_s); got_c.push_back(cyc);
      end
      if (m_exec) begin
        m_res = alu(m_a, m_b, m_s); m_rsel = m_s; m_hold = 1; m_exec = 0;
      end else if (m_hold) begin
        if (res_ready) begin
          m_done++; m_hold = 0;
          if (mn > 0) m_issue();
        end
      end else if (mn > 0) begin
        m_issue();
      end
      if (cmd_valid && mn < DEPTH) begin
        mc.a = cmd_in1; mc.b = cmd_in2; mc.s = cmd_sel;
        mq.push_back(mc);
        sb_d.push_back(alu(cmd_in1, cmd_in2, cmd_sel)); sb_s.push_back(cmd_sel);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_init) begin
      chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
      chk("fifo_count", fifo_count, mq.size());
      chk("res_valid", res_valid, m_hold);
      chk("alu_in1", alu_in1, m_a);
      chk("alu_in2", alu_in2, m_b);
      chk("alu_sel", alu_sel, m_s);
      chk("res_data", res_data, m_res);
      chk("res_sel", res_sel, m_rsel);
`ifdef ALU_CMD_STATS_EN
      chk("stat_done", stat_done, m_done);
      chk("stat_stall", stat_stall, m_stall);
`endif
    end
    prev_valid = res_valid; prev_d = res_data; prev_s = res_sel;
  end

  // ---------------- stimulus ----------------
  task automatic start_cmd(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
    cmd_valid = 1; cmd_in1 = a; cmd_in2 = b; cmd_sel = s;
  endtask

  task automatic wait_accept();
    bit r, ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      r = cmd_ready;
      @(negedge clk);
      if (r) begin ok = 1; break; end
    end
    chk("accept_in_time", ok, 1);
    cmd_valid = 0;
  endtask

  task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
    start_cmd(a, b, s);
    wait_accept();
  endtask

  task automatic wait_res_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("res_valid_in_time", ok, 1);
  endtask

  logic [15:0] sweep_exp [4];
  int base;

  initial begin
    sweep_exp[0] = 16'd523; sweep_exp[1] = 16'd277; sweep_exp[2] = 16'd16; sweep_exp[3] = 16'd507;
    rst = 1; cmd_valid = 0; cmd_in1 = 0; cmd_in2 = 0; cmd_sel = 0; res_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_sel", res_sel, 0);
    rst = 0;

    // single command: operands after N+1, result after N+2
    push_cmd(16'd400, 16'd123, 2'd0);
    @(negedge clk);
    chk("single_alu_in1", alu_in1, 400);
    chk("single_alu_in2", alu_in2, 123);
    chk("single_not_yet_valid", res_valid, 0);
    @(negedge clk);
    chk("single_valid", res_valid, 1);
    chk("single_data", res_data, 523);
    chk("single_sel", res_sel, 0);
    repeat (4) @(negedge clk);

    // opcode sweep, back-to-back
    base = got_d.size();
    for (int s = 0; s < 4; s++) push_cmd(16'd400, 16'd123, 2'(s));
    repeat (12) @(negedge clk);
    chk("sweep_count", got_d.size() - base, 4);
    if (got_d.size() - base == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("sweep_data", got_d[base+k], sweep_exp[k]);
        chk("sweep_tag", got_s[base+k], k);
        if (k > 0) chk("sweep_spacing", got_c[base+k] - got_c[base+k-1], 2);
      end
    end
`ifdef ALU_CMD_STATS_EN
    chk("stat_done_5", stat_done, 5);
`endif

    // fill / backpressure
    res_ready = 0;
    base = got_d.size();
    for (int i = 0; i < 5; i++) push_cmd(16'(100 + i), 16'd50, 2'(i % 4));
    start_cmd(16'd105, 16'd50, 2'd1);
    repeat (6) @(negedge clk);
    chk("fill_count", fifo_count, 4);
    chk("fill_ready_low", cmd_ready, 0);
    chk("fill_held_data", res_data, 150);
    chk("fill_one_issued", alu_in1, 100);
    res_ready = 1;
    wait_accept();
`ifdef ALU_CMD_STATS_EN
    chk("stat_stall_7", stat_stall, 7);
`endif
    repeat (16) @(negedge clk);
    chk("fill_delivered", got_d.size() - base, 6);
    if (got_d.size() - base == 6) begin
      chk("fill_last_data", got_d[base+5], 55);
      chk("fill_last_tag", got_s[base+5], 1);
    end

    // result hold for 10 cycles
    res_ready = 0;
    push_cmd(16'd1111, 16'd2222, 2'd1);
    push_cmd(16'd5, 16'd3, 2'd3);
    wait_res_valid();
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, 64425);
      chk("hold_sel", res_sel, 1);
      chk("hold_no_issue", alu_in1, 1111);
      @(negedge clk);
    end
    res_ready = 1;
    @(negedge clk);
    chk("release_valid_low", res_valid, 0);
    chk("release_issue_in1", alu_in1, 5);
    @(negedge clk);
    chk("release_next_valid", res_valid, 1);
    chk("release_next_data", res_data, 7);
    chk("release_next_sel", res_sel, 3);
    repeat (4) @(negedge clk);

    // reset with work queued and a result held
    res_ready = 0;
    push_cmd(16'd7, 16'd7, 2'd0);
    push_cmd(16'd8, 16'd1, 2'd1);
    push_cmd(16'd9, 16'd2, 2'd2);
    push_cmd(16'd10, 16'd3, 2'd3);
    wait_res_valid();
    chk("pre_rst_count", fifo_count, 3);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_alu_in1", alu_in1, 0);
    chk("mid_rst_alu_in2", alu_in2, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_res_sel", res_sel, 0);
`ifdef ALU_CMD_STATS_EN
    chk("mid_rst_stat_done", stat_done, 0);
    chk("mid_rst_stat_stall", stat_stall, 0);
`endif
    rst = 0; res_ready = 1;
    base = got_d.size();
    push_cmd(16'd9, 16'd4, 2'd0);
    repeat (6) @(negedge clk);
    chk("post_rst_one_result", got_d.size() - base, 1);
    if (got_d.size() - base == 1) chk("post_rst_data", got_d[base], 13);
    chk("drained", sb_d.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end
endmodule
